card_pile_ctrl: RTL and testbench

Parametrised per-player card pile manager: holds deck, hand and discard piles as on-chip stacks and executes draw, gain, discard-hand and stream-hand commands from the turn controller. When a draw needs a card and the deck is empty, it reshuffles the discard pile into the deck (LFSR-driven). It replaces the fixed-size deck/hand/discard logic inside the card control top level and adds reshuffle, a command handshake and error reporting.

---
 rtl/card_pile_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_card_pile_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/card_pile_ctrl.sv
// Per-player deck/hand/discard stacks with a one-command-at-a-time handshake and auto-reshuffle on empty deck.
// Optional CARD_SHUFFLE_EN: LFSR-randomised reshuffle insertion; otherwise discards return to the deck in order.
module card_pile_ctrl #(
  parameter int CARD_W     = 4,
  parameter int PILE_DEPTH = 32,
  parameter int HAND_MAX   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [2:0]                      cmd,
  input  logic [$clog2(HAND_MAX+1)-1:0]   cmd_arg,
  input  logic [CARD_W-1:0]               cmd_card,
  output logic [CARD_W-1:0]               card_stream,
  output logic                            broadcasting,
  output logic [$clog2(PILE_DEPTH+1)-1:0] deck_count,
  output logic [$clog2(PILE_DEPTH+1)-1:0] discard_count,
  output logic [$clog2(HAND_MAX+1)-1:0]   hand_count,
  output logic                            done,
  output logic                            err
);
  localparam int PW  = $clog2(PILE_DEPTH+1);
  localparam int HW  = $clog2(HAND_MAX+1);
  localparam int PWR = $clog2(PILE_DEPTH);
  localparam int HIW = (HAND_MAX > 1) ? $clog2(HAND_MAX) : 1;

  localparam logic [2:0] C_DRAW   = 3'd1;
  localparam logic [2:0] C_GAIN   = 3'd2;
  localparam logic [2:0] C_DISC   = 3'd3;
  localparam logic [2:0] C_STREAM = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_RESHUF, S_DISC, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     deck_cnt_q, deck_cnt_d, disc_cnt_q, disc_cnt_d;
  logic [HW-1:0]     hand_cnt_q, hand_cnt_d, rem_q, rem_d, idx_q, idx_d;
  logic              done_q, done_d, err_q, err_d, bcast_q, bcast_d;
  logic [CARD_W-1:0] stream_q, stream_d;
  logic [CARD_W-1:0] deck_q [PILE_DEPTH];
  logic [CARD_W-1:0] deck_d [PILE_DEPTH];
  logic [CARD_W-1:0] disc_q [PILE_DEPTH];
  logic [CARD_W-1:0] disc_d [PILE_DEPTH];
  logic [CARD_W-1:0] hand_q [HAND_MAX];
  logic [CARD_W-1:0] hand_d [HAND_MAX];

  logic [PWR-1:0] deck_top, disc_top, ins_j;
  logic [HIW-1:0] hand_top;
  logic           hand_full, disc_full;

  assign deck_top  = PWR'(deck_cnt_q - PW'(1));
  assign disc_top  = PWR'(disc_cnt_q - PW'(1));
  assign hand_top  = HIW'(hand_cnt_q - HW'(1));
  assign hand_full = (hand_cnt_q == HW'(HAND_MAX));
  assign disc_full = (disc_cnt_q == PW'(PILE_DEPTH));

`ifdef CARD_SHUFFLE_EN
  localparam int PRW = 2 * PWR;
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // Scale a PWR-bit random value into 0..k so the incoming card lands uniformly among k+1 slots.
  assign ins_j  = PWR'((PRW'(lfsr_q[PWR-1:0]) * PRW'(deck_cnt_q + PW'(1))) >> PWR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign ins_j = PWR'(deck_cnt_q);
`endif

  always_comb begin
    state_d    = state_q;
    deck_cnt_d = deck_cnt_q;
    disc_cnt_d = disc_cnt_q;
    hand_cnt_d = hand_cnt_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    err_d      = err_q;
    bcast_d    = 1'b0;
    stream_d   = '0;
    deck_d     = deck_q;
    disc_d     = disc_q;
    hand_d     = hand_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        err_d = 1'b0;
        case (cmd)
          C_DRAW: if (cmd_arg == '0) done_d = 1'b1;
                  else begin rem_d = cmd_arg; state_d = S_DRAW; end
          C_GAIN: begin
            done_d = 1'b1;
            if (disc_full) err_d = 1'b1;
            else begin
              disc_d[PWR'(disc_cnt_q)] = cmd_card;
              disc_cnt_d = disc_cnt_q + PW'(1);
            end
          end
          C_DISC: if (hand_cnt_q == '0) done_d = 1'b1;
                  else state_d = S_DISC;
          C_STREAM: if (hand_cnt_q == '0) done_d = 1'b1;
                    else begin
                      bcast_d  = 1'b1;
                      stream_d = hand_q[0];
                      idx_d    = HW'(1);
                      state_d  = S_STREAM;
                    end
          default: done_d = 1'b1;
        endcase
      end
      S_DRAW: begin
        if (rem_q == '0) begin
          state_d = S_IDLE; done_d = 1'b1;
        end else if (hand_full) begin
          state_d = S_IDLE; done_d = 1'b1; err_d = 1'b1;
        end else if (deck_cnt_q != '0) begin
          hand_d[HIW'(hand_cnt_q)] = deck_q[deck_top];
          hand_cnt_d = hand_cnt_q + HW'(1);
          deck_cnt_d = deck_cnt_q - PW'(1);
          rem_d      = rem_q - HW'(1);
          // Finish on the edge that moves the last card so done lands n+1 cycles after accept.
          if (rem_q == HW'(1)) begin state_d = S_IDLE; done_d = 1'b1; end
        end else if (disc_cnt_q != '0) begin
          state_d = S_RESHUF;
        end else begin
          state_d = S_IDLE; done_d = 1'b1; err_d = 1'b1;
        end
      end
      S_RESHUF: begin
        deck_d[PWR'(deck_cnt_q)] = deck_q[ins_j];
        deck_d[ins_j]            = disc_q[disc_top];
        deck_cnt_d = deck_cnt_q + PW'(1);
        disc_cnt_d = disc_cnt_q - PW'(1);
        if (disc_cnt_q == PW'(1)) state_d = S_DRAW;
      end
      S_DISC: begin
        if (disc_full) begin
          state_d = S_IDLE; done_d = 1'b1; err_d = 1'b1;
        end else begin
          disc_d[PWR'(disc_cnt_q)] = hand_q[hand_top];
          disc_cnt_d = disc_cnt_q + PW'(1);
          hand_cnt_d = hand_cnt_q - HW'(1);
          if (hand_cnt_q == HW'(1)) begin state_d = S_IDLE; done_d = 1'b1; end
        end
      end
      S_STREAM: begin
        if (idx_q == hand_cnt_q) begin
          state_d = S_IDLE; done_d = 1'b1;
        end else begin
          bcast_d  = 1'b1;
          stream_d = hand_q[HIW'(idx_q)];
          idx_d    = idx_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      deck_cnt_q <= '0;
      disc_cnt_q <= '0;
      hand_cnt_q <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bcast_q    <= 1'b0;
      stream_q   <= '0;
    end else begin
      state_q    <= state_d;
      deck_cnt_q <= deck_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      hand_cnt_q <= hand_cnt_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
      bcast_q    <= bcast_d;
      stream_q   <= stream_d;
    end
  end

  // Pile storage is deliberately unreset; only the counts define which entries are live.
  always_ff @(posedge clk) begin
    deck_q <= deck_d;
    disc_q <= disc_d;
    hand_q <= hand_d;
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign card_stream   = stream_q;
  assign broadcasting  = bcast_q;
  assign deck_count    = deck_cnt_q;
  assign discard_count = disc_cnt_q;
  assign hand_count    = hand_cnt_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_card_pile_ctrl.sv
// Scoreboard bench for card_pile_ctrl: queue-based pile model predicts done/err/counts/latency and streamed cards.
module tb_card_pile_ctrl;
  localparam int CARD_W     = 4;
  localparam int PILE_DEPTH = 32;
  localparam int HAND_MAX   = 8;
  localparam int PW         = $clog2(PILE_DEPTH+1);
  localparam int HW         = $clog2(HAND_MAX+1);
  localparam logic [2:0] C_NOP = 3'd0, C_DRAW = 3'd1, C_GAIN = 3'd2, C_DISC = 3'd3, C_STREAM = 3'd4;

  typedef struct {
    int    err;
    int    deck;
    int    disc;
    int    hand;
    int    lat;
    string name;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd = '0;
  logic [HW-1:0]     cmd_arg = '0;
  logic [CARD_W-1:0] cmd_card = '0;
  logic [CARD_W-1:0] card_stream;
  logic              broadcasting;
  logic [PW-1:0]     deck_count, discard_count;
  logic [HW-1:0]     hand_count;
  logic              done, err;

  int   tests = 0, fails = 0, cyc = 0, acc_cyc = 0;
  bit   loose = 1'b0;
  int   m_deck[$], m_disc[$], m_hand[$];
  int   pend_s[$], exp_s[$], got_q[$], gained[$];
  exp_t exp_q[$];
  exp_t me;
  int   ms;

  card_pile_ctrl #(.CARD_W(CARD_W), .PILE_DEPTH(PILE_DEPTH), .HAND_MAX(HAND_MAX)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_arg(cmd_arg), .cmd_card(cmd_card), .card_stream(card_stream), .broadcasting(broadcasting),
    .deck_count(deck_count), .discard_count(discard_count), .hand_count(hand_count),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model: piles are queues whose back is the top card.
  task automatic model(input logic [2:0] c, input int arg, input int card, output exp_t e);
    int extra;
    int hc;
    extra = 0;
    e.err = 0;
    e.lat = 1;
    case (c)
      C_DRAW: begin
        e.name = "draw";
        for (int i = 0; i < arg; i++) begin
          if (m_hand.size() == HAND_MAX) begin e.err = 1; break; end
          if (m_deck.size() == 0) begin
            if (m_disc.size() == 0) begin e.err = 1; break; end
            extra += m_disc.size() + 1;
            while (m_disc.size() > 0) m_deck.push_back(m_disc.pop_back());
          end
          m_hand.push_back(m_deck.pop_back());
        end
        e.lat = e.err ? -1 : arg + 1 + extra;
      end
      C_GAIN: begin
        e.name = "gain";
        if (m_disc.size() == PILE_DEPTH) e.err = 1;
        else m_disc.push_back(card);
      end
      C_DISC: begin
        e.name = "discard";
        hc = m_hand.size();
        while (m_hand.size() > 0) begin
          if (m_disc.size() == PILE_DEPTH) begin e.err = 1; break; end
          m_disc.push_back(m_hand.pop_back());
        end
        e.lat = e.err ? -1 : hc + 1;
      end
      C_STREAM: begin
        e.name = "stream";
        foreach (m_hand[i]) pend_s.push_back(m_hand[i]);
        e.lat = m_hand.size() + 1;
      end
      default: e.name = "nop";
    endcase
    e.deck = m_deck.size();
    e.disc = m_disc.size();
    e.hand = m_hand.size();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    #1;
    exp_q.delete(); exp_s.delete(); pend_s.delete();
    m_deck.delete(); m_disc.delete(); m_hand.delete();
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_broadcasting", int'(broadcasting), 0);
    chk("rst_card_stream", int'(card_stream), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_deck_count", int'(deck_count), 0);
    chk("rst_discard_count", int'(discard_count), 0);
    chk("rst_hand_count", int'(hand_count), 0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic issue(input logic [2:0] c, input int arg, input int card, input bit wait_done);
    exp_t e;
    int   g;
    model(c, arg, card, e);
    cmd = c;
    cmd_arg = HW'(arg);
    cmd_card = CARD_W'(card);
    cmd_valid = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back(e);
    foreach (pend_s[i]) exp_s.push_back(pend_s[i]);
    pend_s.delete();
    if (wait_done) begin
      g = 0;
      while (exp_q.size() != 0 && g < 400) begin @(posedge clk); #1; g++; end
      if (exp_q.size() != 0) begin
        chk({e.name, "_timeout"}, exp_q.size(), 0);
        apply_reset();
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (broadcasting) begin
        if (loose) got_q.push_back(int'(card_stream));
        chk("stream_expected", int'(exp_s.size() != 0), 1);
        if (exp_s.size() != 0) begin
          ms = exp_s.pop_front();
          if (!loose) chk("stream_card", int'(card_stream), ms);
        end
      end
      if (done) begin
        chk("done_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          me = exp_q.pop_front();
          chk({me.name, "_err"}, int'(err), me.err);
          chk({me.name, "_deck_count"}, int'(deck_count), me.deck);
          chk({me.name, "_discard_count"}, int'(discard_count), me.disc);
          chk({me.name, "_hand_count"}, int'(hand_count), me.hand);
          if (me.lat >= 0) chk({me.name, "_latency"}, cyc - acc_cyc, me.lat);
          chk({me.name, "_stream_len"}, exp_s.size(), 0);
        end
      end
      chk("cmd_ready", int'(cmd_ready), int'(exp_q.size() == 0));
    end
  end

  task automatic fill_discard_and_reset_mid_reshuffle();
    apply_reset();
    for (int i = 0; i < PILE_DEPTH; i++) issue(C_GAIN, 0, $urandom_range(0, 15), 1);
    issue(C_GAIN, 0, 9, 1);
    issue(C_DRAW, 4, 0, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_reshuffle_busy", int'(cmd_ready), 0);
    apply_reset();
    issue(C_GAIN, 0, 3, 1);
  endtask

  initial begin
    logic [2:0] rc;
    int         sel;
    #2;
    apply_reset();
`ifdef CARD_SHUFFLE_EN
    for (int i = 0; i < 16; i++) begin
      gained.push_back($urandom_range(0, 15));
      issue(C_GAIN, 0, gained[i], 1);
    end
    loose = 1'b1;
    issue(C_DRAW, 8, 0, 1);
    issue(C_STREAM, 0, 0, 1);
    issue(C_DISC, 0, 0, 1);
    issue(C_DRAW, 8, 0, 1);
    issue(C_STREAM, 0, 0, 1);
    got_q.sort();
    gained.sort();
    chk("shuffle_multiset_size", got_q.size(), gained.size());
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("shuffle_multiset_card", got_q[i], gained[i]);
    loose = 1'b0;
    fill_discard_and_reset_mid_reshuffle();
`else
    for (int i = 1; i <= 5; i++) issue(C_GAIN, 0, i, 1);
    issue(C_DRAW, 3, 0, 1);
    issue(C_STREAM, 0, 0, 1);
    issue(C_DRAW, 8, 0, 1);
    issue(C_DISC, 0, 0, 1);
    issue(C_STREAM, 0, 0, 1);
    issue(C_NOP, 0, 0, 1);
    issue(3'd5, 0, 0, 1);
    issue(3'd7, 0, 0, 1);
    issue(C_DRAW, 0, 0, 1);
    fill_discard_and_reset_mid_reshuffle();
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       rc = C_GAIN;
      else if (sel < 7)  rc = C_DRAW;
      else if (sel == 7) rc = C_DISC;
      else if (sel == 8) rc = C_STREAM;
      else begin
        rc = 3'($urandom_range(4, 7));
        if (rc == 3'd4) rc = C_NOP;
      end
      issue(rc, $urandom_range(0, 15), $urandom_range(0, 15), 1);
    end
`endif
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
